// File: rtl/brick_pkg.sv
// Shared types, sizing and the level pattern table for the brick map controller.
// The optional score feature is enabled by defining BRICK_SCORE_EN.
package brick_pkg;

    localparam int NUM_BRICKS = 64;
    localparam int COLS       = 8;

    localparam logic [15:0] HIT_SCORE  = 16'd1;
    localparam logic [15:0] KILL_SCORE = 16'd4;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    typedef logic [1:0] brick_t;

    // Initial hit count of brick idx for a given level (row 0 at the top).
    function automatic brick_t brick_pattern(input logic [1:0] level, input logic [5:0] idx);
        logic [2:0] row;
        logic [2:0] col;
        brick_t     val;
        row = idx[5:3];
        col = idx[2:0];
        val = 2'd0;
        case (level)
            2'd0: val = 2'd1;
            2'd1: val = (row < 3'd2) ? 2'd3 : ((row < 3'd4) ? 2'd2 : 2'd1);
            2'd2: val = (row[0] ^ col[0]) ? 2'd2 : 2'd0;
            2'd3: val = ((col == 3'd0) || (col == 3'd7)) ? 2'd3 : 2'd1;
            default: val = 2'd0;
        endcase
        return val;
    endfunction

    // 16-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/brick_pattern_rom.sv
// Combinational lookup of a brick's starting hit count for the selected level.
module brick_pattern_rom
    import brick_pkg::*;
(
    input  logic [1:0] level,
    input  logic [5:0] idx,
    output logic [1:0] value
);

    // Pure table lookup; no state.
    assign value = brick_pattern(level, idx);

endmodule

// File: rtl/brick_map_ctrl.sv
// Brick hit-count map owner: sequences level loads one entry per cycle,
// applies collision hits, tracks remaining bricks and flags level completion.
// Define BRICK_SCORE_EN to add the saturating score register and port.
//
// state | meaning
// IDLE  | map stable, hits accepted unless a load is requested this cycle
// LOAD  | writing pattern entries 0..63, one per cycle; hits and loads refused
module brick_map_ctrl
    import brick_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_req,
    input  logic [1:0] level,
    input  logic       hit_valid,
    input  logic [5:0] hit_idx,
    output logic       hit_ready,
    output logic [1:0] brick [NUM_BRICKS-1:0],
    output logic [6:0] remaining,
    output logic       busy,
    output logic       level_clear
`ifdef BRICK_SCORE_EN
    ,
    output logic [15:0] score
`endif
);

    state_t      state;
    logic [1:0]  level_q;
    logic [5:0]  load_idx;
    logic [1:0]  pat_val;
    logic [1:0]  hit_entry;
    logic        hit_acc;

    brick_pattern_rom u_rom (
        .level (level_q),
        .idx   (load_idx),
        .value (pat_val)
    );

    // Load wins over a same-cycle hit, so readiness depends on load_req directly.
    assign hit_ready = (state == IDLE) && !load_req;
    assign hit_acc   = hit_valid && hit_ready;
    assign hit_entry = brick[hit_idx];

    // Sequencer FSM, map storage, remaining counter and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            level_q     <= 2'd0;
            load_idx    <= 6'd0;
            remaining   <= 7'd0;
            busy        <= 1'b0;
            level_clear <= 1'b0;
            for (int i = 0; i < NUM_BRICKS; i++) begin
                brick[i] <= 2'd0;
            end
        end else begin
            level_clear <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_req) begin
                        state     <= LOAD;
                        busy      <= 1'b1;
                        level_q   <= level;
                        load_idx  <= 6'd0;
                        remaining <= 7'd0;
                    end else if (hit_acc) begin
                        if (hit_entry > 2'd1) begin
                            brick[hit_idx] <= hit_entry - 2'd1;
                        end else if (hit_entry == 2'd1) begin
                            brick[hit_idx] <= 2'd0;
                            remaining      <= remaining - 7'd1;
                            if (remaining == 7'd1) begin
                                level_clear <= 1'b1;
                            end
                        end
                    end
                end
                LOAD: begin
                    brick[load_idx] <= pat_val;
                    if (pat_val != 2'd0) begin
                        remaining <= remaining + 7'd1;
                    end
                    // Index wraps back to 0 after the last entry, ready for the next load.
                    load_idx <= load_idx + 6'd1;
                    if (load_idx == 6'(NUM_BRICKS - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRICK_SCORE_EN
    // Score survives level loads; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score <= 16'd0;
        end else if (hit_acc) begin
            if (hit_entry > 2'd1) begin
                score <= sat_add16(score, HIT_SCORE);
            end else if (hit_entry == 2'd1) begin
                score <= sat_add16(score, KILL_SCORE);
            end
        end
    end
`endif

endmodule

// File: tb/tb_brick_map_ctrl.sv
// Randomized self-checking bench for brick_map_ctrl with a behavioural map model.
module tb_brick_map_ctrl;

    logic       clk;
    logic       rst;
    logic       load_req;
    logic [1:0] level;
    logic       hit_valid;
    logic [5:0] hit_idx;
    logic       hit_ready;
    logic [1:0] brick [63:0];
    logic [6:0] remaining;
    logic       busy;
    logic       level_clear;
`ifdef BRICK_SCORE_EN
    logic [15:0] score;
`endif

    brick_map_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .load_req    (load_req),
        .level       (level),
        .hit_valid   (hit_valid),
        .hit_idx     (hit_idx),
        .hit_ready   (hit_ready),
        .brick       (brick),
        .remaining   (remaining),
        .busy        (busy),
        .level_clear (level_clear)
`ifdef BRICK_SCORE_EN
        ,
        .score       (score)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    int m_map [64];
    int m_rem;
    int m_score;
    int m_clear;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starting hit count per level, written straight from the level descriptions.
    function automatic int ref_pattern(input int lv, input int idx);
        int row = idx / 8;
        int col = idx % 8;
        case (lv)
            0: return 1;
            1: return (row < 2) ? 3 : (row < 4) ? 2 : 1;
            2: return ((row + col) % 2 == 1) ? 2 : 0;
            default: return (col == 0 || col == 7) ? 3 : 1;
        endcase
    endfunction

    task automatic chk_score();
`ifdef BRICK_SCORE_EN
        chk("score", int'(score), m_score);
`endif
    endtask

    task automatic chk_map(input string tag);
        for (int i = 0; i < 64; i++) begin
            chk(tag, int'(brick[i]), m_map[i]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_map[i] = 0;
        m_rem   = 0;
        m_score = 0;
        m_clear = 0;
    endtask

    // Issue a load alongside a competing hit, poke a stray load mid-way, and check the result.
    task automatic load_level(input int lv);
        int n;
        load_req  = 1'b1;
        level     = 2'(lv);
        hit_valid = 1'b1;
        hit_idx   = 6'($urandom_range(0, 63));
        #1;
        chk("hit_ready_vs_load", int'(hit_ready), 0);
        step();
        load_req  = 1'b0;
        hit_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (n == 10) begin
                load_req  = 1'b1;
                level     = 2'(lv + 1);
                hit_valid = 1'b1;
                #1;
                chk("hit_ready_in_load", int'(hit_ready), 0);
            end else begin
                load_req  = 1'b0;
                hit_valid = 1'b0;
            end
            step();
        end
        load_req  = 1'b0;
        hit_valid = 1'b0;
        chk("busy_cycles", n, 64);
        m_rem = 0;
        for (int i = 0; i < 64; i++) begin
            m_map[i] = ref_pattern(lv, i);
            if (m_map[i] != 0) m_rem++;
        end
        step();
        chk("busy_after_load", int'(busy), 0);
        chk("remaining_after_load", int'(remaining), m_rem);
        chk("hit_ready_idle", int'(hit_ready), 1);
        chk("clear_after_load", int'(level_clear), 0);
        chk_map("map_after_load");
    endtask

    task automatic do_hit(input int idx, input bit valid);
        int e;
        hit_valid = valid;
        hit_idx   = 6'(idx);
        #1;
        chk("hit_ready", int'(hit_ready), 1);
        m_clear = 0;
        if (valid) begin
            e = m_map[idx];
            if (e >= 2) begin
                m_map[idx] = e - 1;
                m_score += 1;
            end else if (e == 1) begin
                m_map[idx] = 0;
                m_rem--;
                m_score += 4;
                if (m_rem == 0) m_clear = 1;
            end
            if (m_score > 65535) m_score = 65535;
        end
        step();
        hit_valid = 1'b0;
        chk("hit_brick", int'(brick[idx]), m_map[idx]);
        chk("hit_remaining", int'(remaining), m_rem);
        chk("hit_clear", int'(level_clear), m_clear);
        chk_score();
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        load_req  = 1'b0;
        level     = 2'd0;
        hit_valid = 1'b0;
        hit_idx   = 6'd0;
        model_reset();
        step();
        step();
        rst = 1'b0;
        step();

        chk("rst_busy", int'(busy), 0);
        chk("rst_remaining", int'(remaining), 0);
        chk("rst_clear", int'(level_clear), 0);
        chk("rst_hit_ready", int'(hit_ready), 1);
        chk_score();
        chk_map("rst_map");

        load_level(0);
        do_hit(9, 1'b1);
        for (int k = 0; k < 40; k++) begin
            do_hit($urandom_range(0, 63), $urandom_range(0, 3) != 0);
        end

        load_level(1);
        do_hit(0, 1'b1);
        do_hit(0, 1'b1);
        do_hit(0, 1'b1);
        do_hit(0, 1'b1);

        load_level(2);
        do_hit(0, 1'b1);
        for (int i = 0; i < 64; i++) begin
            if (ref_pattern(2, i) != 0) begin
                do_hit(i, 1'b1);
                do_hit(i, 1'b1);
            end
        end
        step();
        chk("clear_one_cycle", int'(level_clear), 0);
        chk("remaining_zero", int'(remaining), 0);

        load_level(3);
        for (int k = 0; k < 60; k++) begin
            do_hit($urandom_range(0, 63), $urandom_range(0, 3) != 0);
        end

        // Reset partway through a load while entry 30 is being written.
        load_req = 1'b1;
        level    = 2'd1;
        step();
        load_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 30) begin
            n++;
            step();
        end
        chk("busy_before_rst", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_remaining", int'(remaining), 0);
        chk_score();
        chk_map("midrst_map");
        step();
        rst = 1'b0;
        step();
        chk("post_rst_busy", int'(busy), 0);

        load_level(0);
        for (int k = 0; k < 10; k++) begin
            do_hit($urandom_range(0, 63), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
